// File: rtl/i2c_pkg.sv
// Shared constants for the I2C bus front-end: default synchronizer depth
// and counter widths used by the bus filter and its per-line filters.
package i2c_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 32'd2;
  localparam int unsigned FILT_W_DEF      = 32'd4;
  localparam int unsigned IDLE_W_DEF      = 32'd8;

endpackage : i2c_pkg

// File: rtl/i2c_glitch_filter.sv
// Per-line front end: synchronizer chain, stability counter and filtered
// level register. reject_o flags (combinationally) a pending change that
// was abandoned because the synced sample returned to the filtered level.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILT_W      = FILT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              line_i,
  output logic              line_o,
  output logic              reject_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   reject_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchronizer chain; keeps sampling the pin even while filtering is disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
    end
  end

  // Filter decision: count consecutive differing samples, accept once the
  // count has reached the (live) threshold, flag a reject when a pending
  // change collapses back to the filtered level.
  always_comb begin
    cnt_d    = cnt_q;
    filt_d   = filt_q;
    reject_s = 1'b0;
    if (!en_i) begin
      cnt_d  = {FILT_W{1'b0}};
      filt_d = 1'b1;
    end else if (sync_s == filt_q) begin
      cnt_d    = {FILT_W{1'b0}};
      reject_s = (cnt_q != {FILT_W{1'b0}});
    end else if (cnt_q >= filt_len_i) begin
      cnt_d  = {FILT_W{1'b0}};
      filt_d = sync_s;
    end else begin
      cnt_d = cnt_q + FILT_W'(1);
    end
  end

  // Filter state registers; reset drops any pending change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= {FILT_W{1'b0}};
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign line_o   = filt_q;
  assign reject_o = reject_s;

endmodule : i2c_glitch_filter

// File: rtl/i2c_bus_filter.sv
// I2C bus front end: glitch-filtered SCL/SDA, a merged glitch pulse and a
// bus-free indication once both filtered lines have idled high long enough.
module i2c_bus_filter
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILT_W      = FILT_W_DEF,
  parameter int unsigned IDLE_W      = IDLE_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [FILT_W-1:0] i_filt_len,
  input  logic [IDLE_W-1:0] i_idle_len,
  input  logic              i_scl,
  input  logic              i_sda,
  output logic              o_scl,
  output logic              o_sda,
  output logic              o_glitch,
  output logic              o_bus_free
);

  logic              scl_s, sda_s;
  logic              scl_rej_s, sda_rej_s;
  logic              both_high_s;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              bus_free_q, bus_free_d;
  logic              glitch_q, glitch_d;

  i2c_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_W     (FILT_W)
  ) u_scl_filt (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .en_i      (i_en),
    .filt_len_i(i_filt_len),
    .line_i    (i_scl),
    .line_o    (scl_s),
    .reject_o  (scl_rej_s)
  );

  i2c_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_W     (FILT_W)
  ) u_sda_filt (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .en_i      (i_en),
    .filt_len_i(i_filt_len),
    .line_i    (i_sda),
    .line_o    (sda_s),
    .reject_o  (sda_rej_s)
  );

  assign both_high_s = scl_s & sda_s;

  // Idle counting, bus-free decision and merged reject pulse.
  always_comb begin
    idle_d     = idle_q;
    bus_free_d = 1'b0;
    glitch_d   = 1'b0;
    if (!i_en) begin
      idle_d = {IDLE_W{1'b0}};
    end else begin
      if (both_high_s) begin
        if (idle_q == {IDLE_W{1'b1}}) begin
          idle_d = idle_q;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end else begin
        idle_d = {IDLE_W{1'b0}};
      end
      bus_free_d = both_high_s && (idle_q >= i_idle_len);
      glitch_d   = scl_rej_s | sda_rej_s;
    end
  end

  // Top-level status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_q     <= {IDLE_W{1'b0}};
      bus_free_q <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      idle_q     <= idle_d;
      bus_free_q <= bus_free_d;
      glitch_q   <= glitch_d;
    end
  end

  assign o_scl      = scl_s;
  assign o_sda      = sda_s;
  assign o_glitch   = glitch_q;
  assign o_bus_free = bus_free_q;

endmodule : i2c_bus_filter

// File: tb/tb_i2c_bus_filter.sv
// Scoreboard bench for i2c_bus_filter: stimulus pushes (cycle, signal, value)
// expectations; a negedge monitor pops and compares those due on that cycle.
module tb_i2c_bus_filter;

  localparam int SIG_SCL = 0;
  localparam int SIG_SDA = 1;
  localparam int SIG_GL  = 2;
  localparam int SIG_BF  = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] filt_len;
  logic [7:0] idle_len;
  logic       scl, sda;
  logic       o_scl, o_sda, o_glitch, o_bus_free;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int   cyc;
    int   sig;
    logic val;
  } exp_t;

  exp_t sb_q[$];

  i2c_bus_filter dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_filt_len(filt_len),
    .i_idle_len(idle_len),
    .i_scl     (scl),
    .i_sda     (sda),
    .o_scl     (o_scl),
    .o_sda     (o_sda),
    .o_glitch  (o_glitch),
    .o_bus_free(o_bus_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      SIG_SCL: return "o_scl";
      SIG_SDA: return "o_sda";
      SIG_GL:  return "o_glitch";
      default: return "o_bus_free";
    endcase
  endfunction

  // Monitor: compare every expectation due on this cycle, keep the rest.
  always @(negedge clk) begin
    exp_t keep[$];
    logic act;
    keep = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].cyc == cyc) begin
        case (sb_q[i].sig)
          SIG_SCL: act = o_scl;
          SIG_SDA: act = o_sda;
          SIG_GL:  act = o_glitch;
          default: act = o_bus_free;
        endcase
        checks++;
        if (act !== sb_q[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b expected=%b", sig_name(sb_q[i].sig),
                   cyc, act, sb_q[i].val);
        end
      end else begin
        keep.push_back(sb_q[i]);
      end
    end
    sb_q = keep;
  end

  task automatic expect_at(input int d, input int sig, input logic v);
    exp_t e;
    e.cyc = cyc + d;
    e.sig = sig;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_span(input int d0, input int d1, input int sig, input logic v);
    for (int k = d0; k <= d1; k++) expect_at(k, sig, v);
  endtask

  task automatic expect_reset_vals(input int d);
    expect_at(d, SIG_SCL, 1'b1);
    expect_at(d, SIG_SDA, 1'b1);
    expect_at(d, SIG_GL,  1'b0);
    expect_at(d, SIG_BF,  1'b0);
  endtask

  // Advance n rising edges, then settle just after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    filt_len = 4'd3;
    idle_len = 8'd10;
    scl      = 1'b1;
    sda      = 1'b1;

    // Reset values, then bus_free after idle_len+1 cycles from release.
    step(2);
    expect_reset_vals(0);
    step(1);
    rst_n = 1'b1;
    expect_at(10, SIG_BF, 1'b0);
    expect_at(11, SIG_BF, 1'b1);
    step(12);

    // 3-cycle SCL low pulse with filt_len=3 is rejected.
    scl = 1'b0;
    expect_span(1, 9, SIG_SCL, 1'b1);
    expect_at(5, SIG_GL, 1'b0);
    expect_at(6, SIG_GL, 1'b1);
    expect_at(7, SIG_GL, 1'b0);
    expect_span(0, 9, SIG_BF, 1'b1);
    step(3);
    scl = 1'b1;
    step(7);

    // SDA held low: o_sda falls 6 cycles after the pin, bus_free one later.
    sda = 1'b0;
    expect_at(5, SIG_SDA, 1'b1);
    expect_at(6, SIG_SDA, 1'b0);
    expect_at(6, SIG_BF,  1'b1);
    expect_at(7, SIG_BF,  1'b0);
    step(8);

    // Release SDA: bus_free rises 11 cycles after both filtered lines high.
    sda = 1'b1;
    expect_at(5,  SIG_SDA, 1'b0);
    expect_at(6,  SIG_SDA, 1'b1);
    expect_at(16, SIG_BF,  1'b0);
    expect_at(17, SIG_BF,  1'b1);
    step(18);

    // 2-cycle SCL dip leaves bus_free high and yields one glitch pulse.
    scl = 1'b0;
    expect_span(1, 8, SIG_BF,  1'b1);
    expect_span(1, 8, SIG_SCL, 1'b1);
    expect_at(4, SIG_GL, 1'b0);
    expect_at(5, SIG_GL, 1'b1);
    expect_at(6, SIG_GL, 1'b0);
    step(2);
    scl = 1'b1;
    step(7);

    // filt_len 7 -> 1 while SCL count is 4: accepted on the next edge.
    filt_len = 4'd7;
    scl      = 1'b0;
    expect_at(6, SIG_SCL, 1'b1);
    expect_at(7, SIG_SCL, 1'b0);
    expect_span(7, 8, SIG_GL, 1'b0);
    step(6);
    filt_len = 4'd1;
    step(2);
    filt_len = 4'd3;
    scl      = 1'b1;
    expect_at(5, SIG_SCL, 1'b0);
    expect_at(6, SIG_SCL, 1'b1);
    step(7);

    // Enable dropped during SDA low, then restored.
    sda = 1'b0;
    step(8);
    expect_at(0, SIG_SDA, 1'b0);
    en = 1'b0;
    expect_reset_vals(1);
    step(3);
    expect_at(0, SIG_SDA, 1'b1);
    expect_at(0, SIG_BF,  1'b0);
    en = 1'b1;
    expect_at(3, SIG_SDA, 1'b1);
    expect_at(4, SIG_SDA, 1'b0);
    step(5);
    sda = 1'b1;
    expect_at(5, SIG_SDA, 1'b0);
    expect_at(6, SIG_SDA, 1'b1);
    step(19);
    expect_at(0, SIG_BF, 1'b1);

    // Async reset mid-count with filt_len=5: pending change discarded.
    filt_len = 4'd5;
    scl      = 1'b0;
    step(4);
    rst_n = 1'b0;
    scl   = 1'b1;
    expect_reset_vals(0);
    expect_reset_vals(1);
    step(2);
    rst_n = 1'b1;
    expect_span(1, 8, SIG_SCL, 1'b1);
    expect_span(1, 8, SIG_GL,  1'b0);
    expect_at(10, SIG_BF, 1'b0);
    expect_at(11, SIG_BF, 1'b1);
    step(12);

    // Simultaneous rejects on both lines produce a single pulse.
    filt_len = 4'd3;
    scl      = 1'b0;
    sda      = 1'b0;
    expect_at(4, SIG_GL, 1'b0);
    expect_at(5, SIG_GL, 1'b1);
    expect_at(6, SIG_GL, 1'b0);
    expect_at(5, SIG_SCL, 1'b1);
    expect_at(5, SIG_SDA, 1'b1);
    step(2);
    scl = 1'b1;
    sda = 1'b1;
    step(7);

    // filt_len=0 and idle_len=0: synchronizer plus one register, bus_free follows.
    filt_len = 4'd0;
    idle_len = 8'd0;
    sda      = 1'b0;
    expect_at(2, SIG_SDA, 1'b1);
    expect_at(3, SIG_SDA, 1'b0);
    expect_at(3, SIG_BF,  1'b1);
    expect_at(4, SIG_BF,  1'b0);
    step(5);
    sda = 1'b1;
    expect_at(2, SIG_SDA, 1'b0);
    expect_at(3, SIG_SDA, 1'b1);
    expect_at(3, SIG_BF,  1'b0);
    expect_at(4, SIG_BF,  1'b1);
    step(6);

    step(3);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_i2c_bus_filter
